// File: rtl/udp_frame_send.sv
// Streams a stored frame from DRAM to the UDP send core. Each packet is one position
// header word followed by SEG_PIXELS pixel words, and packets are separated by an idle gap.
module udp_frame_send #(
    parameter int          X_SIZE     = 1600,
    parameter int          Y_SIZE     = 900,
    parameter int          SEG_PIXELS = 320,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        active,
    output logic        frame_done,
    output logic        kick,
    input  logic        busy,
    output logic [31:0] read_addr,
    output logic [31:0] read_num,
    input  logic [31:0] buf_dout,
    input  logic        buf_we,
    output logic        w_req,
    input  logic        w_ack,
    output logic        w_enable,
    output logic [31:0] w_data
);

    localparam int PW = $clog2(SEG_PIXELS + 1);
    localparam int AW = (SEG_PIXELS > 1) ? $clog2(SEG_PIXELS) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PW-1:0] SEG_CNT  = PW'(SEG_PIXELS);
    localparam logic [11:0]   SEG_X    = 12'(SEG_PIXELS);
    localparam logic [11:0]   X_LIM    = 12'(X_SIZE);
    localparam logic [11:0]   Y_LIM    = 12'(Y_SIZE);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_KICK, S_RD_WAIT, S_REQ, S_SEND, S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   x_q, x_d, y_q, y_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_cnt_q, rd_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          active_q, active_d, frame_done_q, frame_done_d;
    logic [31:0]   read_addr_q, read_addr_d, read_num_q, read_num_d;
    logic [31:0]   seg_addr;
    logic          buf_wr;
    logic [AW-1:0] rd_idx;

    logic [31:0]   seg_buf [SEG_PIXELS];
    logic [31:0]   rdata_q;
    logic          unused_low_byte;

    assign unused_low_byte = ^buf_dout[7:0];

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        wr_ptr_d     = wr_ptr_q;
        rd_cnt_d     = rd_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        active_d     = active_q;
        frame_done_d = 1'b0;
        read_addr_d  = read_addr_q;
        read_num_d   = read_num_q;
        kick         = 1'b0;
        buf_wr       = 1'b0;
        seg_addr     = BASE_ADDR + ((32'(y_q) * 32'(X_SIZE) + 32'(x_q)) << 2);

        case (state_q)
            S_IDLE: begin
                // The done-pulse cycle already sits in IDLE; a start landing on it is dropped.
                if (start && !frame_done_q) begin
                    x_d      = '0;
                    y_d      = '0;
                    active_d = 1'b1;
                    state_d  = S_RD_KICK;
                end
            end
            S_RD_KICK: begin
                if (!busy) begin
                    kick        = 1'b1;
                    read_addr_d = seg_addr;
                    read_num_d  = 32'(SEG_PIXELS);
                    wr_ptr_d    = '0;
                    state_d     = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (buf_we && wr_ptr_q != SEG_CNT) begin
                    buf_wr   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                if (wr_ptr_q == SEG_CNT && !busy) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack) begin
                    rd_cnt_d = '0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                if (rd_cnt_q == SEG_CNT) begin
                    rd_cnt_d  = '0;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    rd_cnt_d = rd_cnt_q + PW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q != GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end else if (x_q + SEG_X != X_LIM) begin
                    x_d     = x_q + SEG_X;
                    state_d = S_RD_KICK;
                end else if (y_q + 12'd1 != Y_LIM) begin
                    x_d     = '0;
                    y_d     = y_q + 12'd1;
                    state_d = S_RD_KICK;
                end else begin
                    x_d          = '0;
                    y_d          = '0;
                    frame_done_d = 1'b1;
                    active_d     = 1'b0;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            wr_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            active_q     <= 1'b0;
            frame_done_q <= 1'b0;
            read_addr_q  <= '0;
            read_num_q   <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            active_q     <= active_d;
            frame_done_q <= frame_done_d;
            read_addr_q  <= read_addr_d;
            read_num_q   <= read_num_d;
        end
    end

    // Reading buffer entry rd_cnt while word rd_cnt is on the bus puts pixel rd_cnt
    // in rdata_q for the next cycle, so pixel 0 directly follows the header.
    assign rd_idx = (rd_cnt_q < SEG_CNT) ? rd_cnt_q[AW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (buf_wr) begin
            seg_buf[wr_ptr_q[AW-1:0]] <= {buf_dout[31:8], 8'h00};
        end
        rdata_q <= seg_buf[rd_idx];
    end

    assign active     = active_q;
    assign frame_done = frame_done_q;
    assign read_addr  = kick ? read_addr_d : read_addr_q;
    assign read_num   = kick ? read_num_d : read_num_q;
    assign w_req      = (state_q == S_REQ) || (state_q == S_SEND);
    assign w_enable   = (state_q == S_SEND);
    assign w_data     = (state_q != S_SEND) ? 32'h0 :
                        (rd_cnt_q == '0)    ? {frame_cnt_q, y_q, x_q} : rdata_q;

endmodule

// File: tb/tb_udp_frame_send.sv
// Bench for udp_frame_send: a table of frame scenarios driven through DRAM and UDP-core
// models, compared against a per-segment reference of addresses, headers and pixels.
module tb_udp_frame_send;

    localparam int          X      = 8;
    localparam int          Y      = 2;
    localparam int          SEG    = 4;
    localparam logic [31:0] BASE   = 32'h1000;
    localparam int          GAP    = 2;
    localparam int          PER_LN = X / SEG;
    localparam int          NSEG   = PER_LN * Y;
    localparam int          PLEN   = SEG + 1;

    logic        clk, rst, start, busy, buf_we, w_ack;
    logic [31:0] buf_dout;
    logic        active, frame_done, kick, w_req, w_enable;
    logic [31:0] read_addr, read_num, w_data;

    udp_frame_send #(
        .X_SIZE(X), .Y_SIZE(Y), .SEG_PIXELS(SEG), .BASE_ADDR(BASE), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .active(active), .frame_done(frame_done),
        .kick(kick), .busy(busy), .read_addr(read_addr), .read_num(read_num),
        .buf_dout(buf_dout), .buf_we(buf_we), .w_req(w_req), .w_ack(w_ack),
        .w_enable(w_enable), .w_data(w_data)
    );

    typedef struct {
        int data_mode;   // 0: word = byte address, 1: random words
        int extra;       // surplus buf_we beats beyond read_num
        int ack_delay;   // cycles w_ack held low in REQ
        int stall;       // check w_req/w_enable during the ack stall
        int mid_start;   // cycle to pulse start mid-frame (-1: none)
        int pre_busy;    // cycles busy is held high before the first kick
        int do_reset;    // abort a frame with rst during SEND word 2 first
        int exp_fcnt;    // expected header frame counter
    } frame_row_t;

    frame_row_t rows [5];

    int checks = 0;
    int errors = 0;
    int data_mode = 0, extra_words = 0, ack_delay = 0, stall_chk = 0;
    int fd_count = 0, wen_noreq = 0;

    logic [31:0] kick_addr_q[$], kick_num_q[$];
    logic [31:0] cur_pkt[$], pkt_word_q[$], dram_word_q[$];
    int          pkt_len_q[$], dram_cnt_q[$];

    logic [31:0] lit_addr [4];
    logic [31:0] lit_hdr  [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_addr(input int seg);
        int yy, xx;
        yy = seg / PER_LN;
        xx = (seg % PER_LN) * SEG;
        return BASE + 32'((yy * X + xx) * 4);
    endfunction

    function automatic logic [31:0] ref_header(input int fc, input int seg);
        int yy, xx;
        yy = seg / PER_LN;
        xx = (seg % PER_LN) * SEG;
        return 32'((fc % 256) * 16777216 + yy * 4096 + xx);
    endfunction

    task automatic clear_queues();
        kick_addr_q.delete();
        kick_num_q.delete();
        pkt_word_q.delete();
        pkt_len_q.delete();
        dram_word_q.delete();
        dram_cnt_q.delete();
        wen_noreq = 0;
    endtask

    // Output monitor: collects kicks and splits the w_enable stream into packets.
    initial begin
        forever begin
            @(negedge clk);
            if (kick) begin
                kick_addr_q.push_back(read_addr);
                kick_num_q.push_back(read_num);
            end
            if (w_enable) begin
                cur_pkt.push_back(w_data);
                if (!w_req) wen_noreq++;
            end else if (cur_pkt.size() > 0) begin
                pkt_len_q.push_back(cur_pkt.size());
                foreach (cur_pkt[i]) pkt_word_q.push_back(cur_pkt[i]);
                cur_pkt.delete();
            end
            if (frame_done) fd_count++;
        end
    end

    // DRAM reader model: busy for the whole burst, buf_we beats with random bubbles.
    initial begin
        logic [31:0] a;
        int n;
        busy = 1'b0;
        buf_we = 1'b0;
        buf_dout = '0;
        forever begin
            @(negedge clk);
            if (kick && !rst) begin
                a = read_addr;
                n = int'(read_num) + extra_words;
                @(posedge clk); #1 busy = 1'b1;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        buf_we = 1'b0;
                        @(posedge clk); #1;
                    end
                    buf_we = 1'b1;
                    buf_dout = (data_mode != 0) ? $urandom : a + 32'(4 * i);
                    dram_word_q.push_back(buf_dout);
                    @(posedge clk); #1;
                end
                buf_we = 1'b0;
                dram_cnt_q.push_back(n);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                busy = 1'b0;
            end
        end
    end

    // UDP core model: grants each request after ack_delay cycles.
    initial begin
        w_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (w_req && !w_enable && !rst) begin
                for (int i = 0; i < ack_delay; i++) begin
                    if (stall_chk != 0) begin
                        check("req_stall_w_req", {31'b0, w_req}, 32'd1);
                        check("req_stall_w_enable", {31'b0, w_enable}, 32'd0);
                    end
                    @(negedge clk);
                end
                w_ack = 1'b1;
                @(negedge clk);
                w_ack = 1'b0;
            end
        end
    end

    task automatic reset_mid_send();
        int wc;
        data_mode = 1; extra_words = 0; ack_delay = 1; stall_chk = 0;
        clear_queues();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wc = 0;
        for (int c = 0; c < 2000 && wc < 3; c++) begin
            @(negedge clk);
            if (w_enable) wc++;
        end
        if (wc < 3) check("reset_reach_send_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_w_enable", {31'b0, w_enable}, 32'd0);
        check("rst_mid_w_req", {31'b0, w_req}, 32'd0);
        check("rst_mid_kick", {31'b0, kick}, 32'd0);
        check("rst_mid_active", {31'b0, active}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_no_words", {31'b0, w_enable}, 32'd0);
    endtask

    task automatic run_frame(input int r, input frame_row_t row);
        int fd0, off, got;
        data_mode = row.data_mode; extra_words = row.extra;
        ack_delay = row.ack_delay; stall_chk = row.stall;
        clear_queues();
        fd0 = fd_count;
        if (row.pre_busy > 0) begin
            @(negedge clk); busy = 1'b1; start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int i = 0; i < row.pre_busy; i++) begin
                check($sformatf("kick_while_busy[%0d]", i), {31'b0, kick}, 32'd0);
                @(negedge clk);
            end
            @(posedge clk); #1 busy = 1'b0;
            @(negedge clk);
            check("kick_after_busy_falls", {31'b0, kick}, 32'd1);
        end else begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            check("kick_latency", {31'b0, kick}, 32'd1);
        end
        got = 0;
        for (int c = 0; c < 3000 && got == 0; c++) begin
            @(negedge clk);
            start = (c == row.mid_start);
            if (frame_done) got = 1;
        end
        if (got == 0) begin
            check($sformatf("frame%0d_done_timeout", r), 32'd0, 32'd1);
        end else begin
            check($sformatf("frame%0d_active_at_done", r), {31'b0, active}, 32'd0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (6) @(negedge clk);
        check($sformatf("frame%0d_start_on_done_ignored", r), {31'b0, active}, 32'd0);
        check($sformatf("frame%0d_done_pulses", r), 32'(fd_count - fd0), 32'd1);
        check($sformatf("frame%0d_kick_count", r), 32'(kick_addr_q.size()), 32'(NSEG));
        check($sformatf("frame%0d_pkt_count", r), 32'(pkt_len_q.size()), 32'(NSEG));
        check($sformatf("frame%0d_wen_without_req", r), 32'(wen_noreq), 32'd0);
        for (int k = 0; k < kick_addr_q.size() && k < NSEG; k++) begin
            check($sformatf("frame%0d_kick%0d_addr", r, k), kick_addr_q[k], ref_addr(k));
            check($sformatf("frame%0d_kick%0d_num", r, k), kick_num_q[k], 32'(SEG));
            if (r == 0) check($sformatf("plan_kick%0d_addr", k), kick_addr_q[k], lit_addr[k]);
        end
        off = 0;
        for (int p = 0; p < pkt_len_q.size() && p < NSEG && p < dram_cnt_q.size(); p++) begin
            int doff;
            doff = 0;
            for (int q = 0; q < p; q++) doff += dram_cnt_q[q];
            check($sformatf("frame%0d_pkt%0d_len", r, p), 32'(pkt_len_q[p]), 32'(PLEN));
            check($sformatf("frame%0d_pkt%0d_header", r, p), pkt_word_q[off],
                  ref_header(row.exp_fcnt, p));
            if (r == 0) check($sformatf("plan_pkt%0d_header", p), pkt_word_q[off], lit_hdr[p]);
            for (int i = 0; i < SEG && i + 1 < pkt_len_q[p]; i++) begin
                check($sformatf("frame%0d_pkt%0d_pix%0d", r, p, i), pkt_word_q[off + 1 + i],
                      dram_word_q[doff + i] & 32'hFFFF_FF00);
                if (r == 0 && p == 0)
                    check($sformatf("plan_pix%0d", i), pkt_word_q[off + 1 + i], 32'h0000_1000);
            end
            off += pkt_len_q[p];
        end
    endtask

    initial begin
        rows[0] = '{0, 0, 0,  0, -1, 0, 0, 0};
        rows[1] = '{1, 2, 1,  0, 40, 0, 0, 1};
        rows[2] = '{1, 0, 10, 1, -1, 0, 0, 2};
        rows[3] = '{1, 1, 3,  0, -1, 5, 0, 3};
        rows[4] = '{1, 0, 2,  0, -1, 0, 1, 0};
        lit_addr = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
        lit_hdr  = '{32'h000000, 32'h000004, 32'h001000, 32'h001004};

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_kick", {31'b0, kick}, 32'd0);
        check("reset_active", {31'b0, active}, 32'd0);
        check("reset_frame_done", {31'b0, frame_done}, 32'd0);
        check("reset_w_req", {31'b0, w_req}, 32'd0);
        check("reset_w_enable", {31'b0, w_enable}, 32'd0);
        check("reset_w_data", w_data, 32'd0);
        check("reset_read_addr", read_addr, 32'd0);
        check("reset_read_num", read_num, 32'd0);
        rst = 1'b0;

        for (int r = 0; r < 5; r++) begin
            if (rows[r].do_reset != 0) reset_mid_send();
            run_frame(r, rows[r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
